// File: rtl/peripheral_dbg_soc_debug_ring_pkg.sv
// Shared types and helpers for the debug ring gateway.
package peripheral_dbg_soc_debug_ring_pkg;

  localparam int unsigned FLIT_DATA_W = 16;

  typedef enum logic [1:0] {IDLE, FWD, DROP} egress_state_e;

  // Subnet id sits in the top subnet_bits of a header's destination address.
  function automatic logic [FLIT_DATA_W-1:0] get_subnet(input logic [FLIT_DATA_W-1:0] data,
                                                        input int unsigned subnet_bits);
    return data >> (FLIT_DATA_W - subnet_bits);
  endfunction

endpackage

// File: rtl/peripheral_dbg_soc_dii_channel.sv
// Debug interconnect (DII) flit type shared by all debug ring blocks.
package peripheral_dbg_soc_dii_channel;

  typedef struct packed {
    logic        valid;
    logic        last;
    logic [15:0] data;
  } dii_flit;

endpackage

// File: rtl/peripheral_dbg_soc_debug_ring_fifo.sv
// Ingress flit FIFO; pointers carry an extra wrap bit to tell full from empty.
module peripheral_dbg_soc_debug_ring_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 17
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic             full, empty, push, pop;

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign in_ready  = !rst && !full;
  assign out_valid = !empty;
  assign out_data  = mem[rd_ptr[AW-1:0]];
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

endmodule

// File: rtl/peripheral_dbg_soc_debug_ring_gateway.sv
// Debug ring terminator: routes remote egress packets to the gateway, drops unclaimed local ones,
// and buffers gateway traffic into the ring head. Optional drop counter: DBG_RING_DROP_COUNT_EN.
module peripheral_dbg_soc_debug_ring_gateway
  import peripheral_dbg_soc_dii_channel::*;
  import peripheral_dbg_soc_debug_ring_pkg::*;
#(
  parameter int unsigned BUFFER_SIZE  = 4,
  parameter int unsigned SUBNET_BITS  = 6,
  parameter int unsigned LOCAL_SUBNET = 0,
  parameter int unsigned CNT_WIDTH    = 16
) (
  input  logic    clk,
  input  logic    rst,
  input  dii_flit ring_tail_in,
  output logic    ring_tail_in_ready,
  output dii_flit ring_head_out,
  input  logic    ring_head_out_ready,
  output dii_flit gw_out,
  input  logic    gw_out_ready,
  input  dii_flit gw_in,
  output logic    gw_in_ready
`ifdef DBG_RING_DROP_COUNT_EN
  ,
  output logic [CNT_WIDTH-1:0] drop_count
`endif
);

  egress_state_e state;
  logic          hdr_remote;
  logic          tail_xfer;

  assign hdr_remote = get_subnet(ring_tail_in.data, SUBNET_BITS) != FLIT_DATA_W'(LOCAL_SUBNET);
  assign tail_xfer  = ring_tail_in.valid && ring_tail_in_ready;

  // Egress routing is combinational so forwarded flits leave in the cycle they arrive.
  always_comb begin
    gw_out             = ring_tail_in;
    gw_out.valid       = 1'b0;
    ring_tail_in_ready = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (hdr_remote) begin
            gw_out.valid       = ring_tail_in.valid;
            ring_tail_in_ready = gw_out_ready;
          end else begin
            ring_tail_in_ready = 1'b1;
          end
        end
        FWD: begin
          gw_out.valid       = ring_tail_in.valid;
          ring_tail_in_ready = gw_out_ready;
        end
        DROP:    ring_tail_in_ready = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else if (tail_xfer) begin
      case (state)
        IDLE:    if (!ring_tail_in.last) state <= hdr_remote ? FWD : DROP;
        FWD:     if (ring_tail_in.last) state <= IDLE;
        DROP:    if (ring_tail_in.last) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DBG_RING_DROP_COUNT_EN
  // Saturating count of dropped local headers.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_count <= '0;
    end else if (tail_xfer && (state == IDLE) && !hdr_remote && !(&drop_count)) begin
      drop_count <= drop_count + CNT_WIDTH'(1);
    end
  end
`endif

  peripheral_dbg_soc_debug_ring_fifo #(
    .DEPTH(BUFFER_SIZE),
    .WIDTH(FLIT_DATA_W + 1)
  ) u_ingress_fifo (
    .clk      (clk),
    .rst      (rst),
    .in_data  ({gw_in.last, gw_in.data}),
    .in_valid (gw_in.valid),
    .in_ready (gw_in_ready),
    .out_data ({ring_head_out.last, ring_head_out.data}),
    .out_valid(ring_head_out.valid),
    .out_ready(ring_head_out_ready)
  );

endmodule
